// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 4-bit shift/rotate engine.
// Accepts one command (select, direction, amount, data) in IDLE, walks the
// data through a 0-3 position barrel stage each cycle until the requested
// amount is consumed, then presents the result until it is taken.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             synchronous abort, highest priority
//   req_valid/ready   command handshake (ready only in IDLE)
//   req_select        0 = shift zero fill, 1 = rotate
//   req_direction     0 = right, 1 = left
//   req_amount        total positions to move (AMT_W bits)
//   req_data          4-bit operand
//   rsp_valid/ready   result handshake (valid only in DONE)
//   rsp_data          data register, meaningful while rsp_valid
//   busy              high in RUN or DONE

// One combinational stage: moves 4 bits by 0-3 positions.
module barrel_shifter (
    input  logic [3:0] data,
    input  logic [1:0] amount,
    input  logic       select,
    input  logic       direction,
    output logic [3:0] result
);
    logic [7:0] dbl;

    always_comb begin
        result = data;
        dbl    = {data, data};
        if (select) begin
            // Rotate via a doubled word: the wrapped bits fall into the window.
            if (direction) begin
                dbl    = dbl << amount;
                result = dbl[7:4];
            end else begin
                dbl    = dbl >> amount;
                result = dbl[3:0];
            end
        end else begin
            if (direction) result = data << amount;
            else           result = data >> amount;
        end
    end
endmodule

module shift_sequencer #(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_select,
    input  logic             req_direction,
    input  logic [AMT_W-1:0] req_amount,
    input  logic [3:0]       req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_data,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       data_q, data_d;
    logic [AMT_W-1:0] rem_q, rem_d, rem_step;
    logic             sel_q, sel_d, dir_q, dir_d;
    logic [AMT_W+1:0] rem_ext;
    logic [1:0]       step;
    logic [3:0]       stage_out;

    // Widened so the min(remaining, 3) compare works for any AMT_W.
    assign rem_ext  = {2'b00, rem_q};
    assign step     = (rem_ext >= (AMT_W+2)'(3)) ? 2'd3 : rem_ext[1:0];
    assign rem_step = rem_q - AMT_W'(step);

    barrel_shifter u_stage (
        .data      (data_q),
        .amount    (step),
        .select    (sel_q),
        .direction (dir_q),
        .result    (stage_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= 4'b0000;
            rem_q   <= '0;
            sel_q   <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        if (flush) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    data_d  = req_data;
                    sel_d   = req_select;
                    dir_d   = req_direction;
                    rem_d   = req_amount;
                    state_d = (req_amount != '0) ? RUN : DONE;
                end
                RUN: begin
                    data_d = stage_out;
                    rem_d  = rem_step;
                    if (rem_step == '0) state_d = DONE;
                end
                DONE: if (rsp_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = data_q;
endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_select = 1'b0;
    logic             req_direction = 1'b0;
    logic [AMT_W-1:0] req_amount = '0;
    logic [3:0]       req_data = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [3:0]       rsp_data;
    logic             busy;

    typedef struct {
        logic [3:0] data;
        int         lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    shift_sequencer #(.AMT_W(AMT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_select    (req_select),
        .req_direction (req_direction),
        .req_amount    (req_amount),
        .req_data      (req_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: shift/rotate by the full amount in one go.
    function automatic logic [3:0] model(input logic sel, input logic dir,
                                         input logic [3:0] d, input int amt);
        logic [7:0] w;
        int         r;
        if (sel) begin
            r = amt % 4;
            w = {d, d};
            if (dir) begin w = w << r; return w[7:4]; end
            else     begin w = w >> r; return w[3:0]; end
        end
        if (amt >= 4) return 4'b0000;
        return dir ? 4'(d << amt) : 4'(d >> amt);
    endfunction

    // Call right after a negedge. Drives one command, lets it be accepted,
    // then scrambles the inputs so a leaky latch would show up.
    task automatic drive_req(input logic sel, input logic dir, input int amt, input logic [3:0] d);
        exp_t e;
        req_valid     = 1'b1;
        req_select    = sel;
        req_direction = dir;
        req_amount    = AMT_W'(amt);
        req_data      = d;
        e.data = model(sel, dir, d, amt);
        e.lat  = 1 + (amt + 2) / 3;
        q.push_back(e);
        @(posedge clk); #1;
        req_valid     = 1'b0;
        req_select    = 1'($urandom);
        req_direction = 1'($urandom);
        req_amount    = AMT_W'($urandom);
        req_data      = 4'($urandom);
    endtask

    // Count edges from acceptance to rsp_valid and compare against the head.
    task automatic wait_rsp(input string tag, input bit consume);
        exp_t e;
        int   lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) begin
            chk({tag, "_timeout"}, rsp_valid, 1);
            return;
        end
        if (q.size() == 0) begin
            chk({tag, "_unexpected"}, rsp_valid, 0);
            return;
        end
        e = q.pop_front();
        chk({tag, "_data"}, rsp_data, e.data);
        chk({tag, "_lat"}, lat, e.lat);
        chk({tag, "_busy"}, busy, 1);
        if (consume) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            chk({tag, "_idle_ready"}, req_ready, 1);
            chk({tag, "_idle_valid"}, rsp_valid, 0);
        end
    endtask

    initial begin
        logic [3:0] held;
        // Reset state
        #3;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", rsp_data, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        drive_req(1'b0, 1'b1, 1, 4'b1011);  wait_rsp("shl1", 1'b1);
        @(negedge clk);
        drive_req(1'b1, 1'b0, 7, 4'b1001);  wait_rsp("ror7", 1'b1);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 9, 4'b1111);  wait_rsp("shr9", 1'b1);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 0, 4'b0101);  wait_rsp("amt0", 1'b1);
        @(negedge clk);
        drive_req(1'b1, 1'b1, 15, 4'b1000); wait_rsp("rol15", 1'b1);

        // Backpressure: hold result, pulse a competing request
        @(negedge clk);
        drive_req(1'b1, 1'b1, 3, 4'b0110);
        wait_rsp("bp", 1'b0);
        held = rsp_data;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = (i != 1);
            req_data  = 4'b1010;
            req_amount = AMT_W'(0);
            @(posedge clk); #1;
            chk("bp_stable", rsp_data, held);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_ready", req_ready, 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_release", req_ready, 1);
        chk("bp_gone", rsp_valid, 0);

        // Async reset mid-run, then accept on first edge after release
        @(negedge clk);
        drive_req(1'b0, 1'b1, 15, 4'b1111);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", req_ready, 1);
        chk("arst_valid", rsp_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", rsp_data, 4'b0000);
        void'(q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        drive_req(1'b0, 1'b1, 2, 4'b0001);
        wait_rsp("post_rst", 1'b1);

        // Flush in RUN
        @(negedge clk);
        drive_req(1'b0, 1'b1, 9, 4'b0011);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(q.pop_back());
        chk("flrun_busy", busy, 0);
        chk("flrun_valid", rsp_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("flrun_quiet", rsp_valid, 0);
        end

        // Flush in DONE
        @(negedge clk);
        drive_req(1'b1, 1'b0, 0, 4'b1100);
        chk("fldone_pre", rsp_valid, 1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(q.pop_back());
        chk("fldone_valid", rsp_valid, 0);
        chk("fldone_ready", req_ready, 1);

        // Flush beats acceptance in IDLE
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_amount = AMT_W'(0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        chk("flidle_busy", busy, 0);
        @(posedge clk); #1;
        chk("flidle_valid", rsp_valid, 0);

        // Random commands
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive_req(1'($urandom), 1'($urandom), int'($urandom_range(0, 15)), 4'($urandom));
            wait_rsp("rnd", 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
